// File: rtl/strhw_block_feeder.sv
// Block feeder: packs a byte stream into 512-bit blocks, hands each block to the
// hash control logic over a trigger/state handshake, and presents the digest.

package strhw_block_feeder_pkg;
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    BUSY  = 2'd1,
    READY = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

module strhw_block_feeder
  import strhw_block_feeder_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  input  logic [7:0]   s_data_i,
  input  logic         s_last_i,
  output logic         s_ready_o,
  input  logic         hash_size_i,
  output logic         cl_trg_o,
  input  state_t       cl_state_i,
  output logic [511:0] cl_block_o,
  output logic [6:0]   cl_block_size_o,
  output logic         cl_hash_size_o,
  input  logic [511:0] cl_hash_i,
  output logic         m_hash_valid_o,
  output logic [511:0] m_hash_o,
  input  logic         m_hash_ready_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_END,
    S_RELEASE,
    S_OUT
  } fsm_t;

  fsm_t         state_q, state_d;
  logic [511:0] buf_q, buf_d;
  logic [6:0]   cnt_q, cnt_d;
  logic         hs_q, hs_d;
  logic         trg_q, trg_d;
  logic [511:0] hash_q, hash_d;
  logic         valid_q, valid_d;
  logic         first_q, first_d;   // next issue is the first block of the message
  logic         empty_q, empty_d;   // an empty trailing block is still owed

  logic         rdy;
  logic         accept;
  logic [6:0]   cnt_inc;

  assign rdy     = (state_q == S_IDLE) || (state_q == S_FILL);
  // Ready is gated by reset so it reads 0 while reset is held and 1 as soon as it lifts.
  assign s_ready_o = rst_ni & rdy;
  assign accept  = s_valid_i & rdy;
  assign cnt_inc = (cnt_q >= 7'd64) ? 7'd64 : cnt_q + 7'd1;

  assign cl_trg_o        = trg_q;
  assign cl_block_o      = buf_q;
  assign cl_block_size_o = cnt_q;
  assign cl_hash_size_o  = hs_q;
  assign m_hash_valid_o  = valid_q;
  assign m_hash_o        = hash_q;

  // Next-state and datapath update for the feeder FSM.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    hs_d    = hs_q;
    trg_d   = trg_q;
    hash_d  = hash_q;
    valid_d = valid_q;
    first_d = first_q;
    empty_d = empty_q;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          hs_d       = hash_size_i;
          buf_d      = '0;
          buf_d[7:0] = s_data_i;
          cnt_d      = 7'd1;
          first_d    = 1'b1;
          empty_d    = 1'b0;
          state_d    = s_last_i ? S_ISSUE : S_FILL;
        end
      end
      S_FILL: begin
        if (accept) begin
          buf_d[{cnt_q[5:0], 3'b000} +: 8] = s_data_i;
          cnt_d = cnt_inc;
          if (s_last_i || (cnt_q == 7'd63)) begin
            state_d = S_ISSUE;
            empty_d = s_last_i && (cnt_q == 7'd63);
          end
        end
      end
      S_ISSUE: begin
        if ((first_q && (cl_state_i == CLEAR)) || (!first_q && (cl_state_i == READY))) begin
          trg_d   = 1'b1;
          first_d = 1'b0;
          state_d = S_WAIT_BUSY;
        end
      end
      S_WAIT_BUSY: begin
        if (cl_state_i == BUSY) begin
          trg_d   = 1'b0;
          state_d = S_WAIT_END;
        end
      end
      S_WAIT_END: begin
        if (cl_state_i == READY) begin
          buf_d = '0;
          cnt_d = '0;
          if (empty_q) begin
            empty_d = 1'b0;
            state_d = S_ISSUE;
          end else begin
            state_d = S_FILL;
          end
        end else if (cl_state_i == DONE) begin
          // DONE always finishes the message, even if more blocks were expected.
          hash_d  = cl_hash_i;
          empty_d = 1'b0;
          trg_d   = 1'b1;
          state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (cl_state_i == CLEAR) begin
          trg_d   = 1'b0;
          valid_d = 1'b1;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (m_hash_ready_i) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      hs_q    <= 1'b0;
      trg_q   <= 1'b0;
      hash_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      hs_q    <= hs_d;
      trg_q   <= trg_d;
      hash_q  <= hash_d;
      valid_q <= valid_d;
      first_q <= first_d;
      empty_q <= empty_d;
    end
  end

endmodule

// File: tb/tb_strhw_block_feeder.sv
// Bench for strhw_block_feeder: message-level reference, control-logic model,
// digest consumer with scoreboard queues.

module tb_strhw_block_feeder;
  import strhw_block_feeder_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid_i;
  logic [7:0]   s_data_i;
  logic         s_last_i;
  logic         s_ready_o;
  logic         hash_size_i;
  logic         cl_trg_o;
  state_t       cl_state_i;
  logic [511:0] cl_block_o;
  logic [6:0]   cl_block_size_o;
  logic         cl_hash_size_o;
  logic [511:0] cl_hash_i;
  logic         m_hash_valid_o;
  logic [511:0] m_hash_o;
  logic         m_hash_ready_i;

  always #5 clk = ~clk;

  strhw_block_feeder dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .s_valid_i       (s_valid_i),
    .s_data_i        (s_data_i),
    .s_last_i        (s_last_i),
    .s_ready_o       (s_ready_o),
    .hash_size_i     (hash_size_i),
    .cl_trg_o        (cl_trg_o),
    .cl_state_i      (cl_state_i),
    .cl_block_o      (cl_block_o),
    .cl_block_size_o (cl_block_size_o),
    .cl_hash_size_o  (cl_hash_size_o),
    .cl_hash_i       (cl_hash_i),
    .m_hash_valid_o  (m_hash_valid_o),
    .m_hash_o        (m_hash_o),
    .m_hash_ready_i  (m_hash_ready_i)
  );

  typedef struct {
    logic [511:0] data;
    logic [6:0]   size;
    logic         hs;
  } blk_t;

  blk_t         exp_blk[$];
  logic [511:0] exp_hash[$];
  int unsigned  n_checks = 0;
  int unsigned  n_pass = 0;
  int unsigned  msgs_sent = 0;
  int unsigned  digests_seen = 0;
  bit           hold_mode = 1'b0;
  int           ctl_delay = -1;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Control-logic model: answers triggers, checks every issued block against the reference.
  initial begin : ctl_model
    logic [511:0] snap_blk;
    logic [6:0]   snap_size;
    logic         snap_hs;
    logic [511:0] h;
    bit           trig_seen;
    int unsigned  dly, dly_t, busy_left, rel_t;
    blk_t         e;
    trig_seen = 0; dly = 0; dly_t = 0; busy_left = 0; rel_t = 0;
    snap_blk = '0; snap_size = '0; snap_hs = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cl_state_i = CLEAR;
        trig_seen  = 0;
        dly        = 0;
        continue;
      end
      case (cl_state_i)
        CLEAR, READY: begin
          if (cl_trg_o) begin
            if (!trig_seen) begin
              trig_seen = 1;
              snap_blk  = cl_block_o;
              snap_size = cl_block_size_o;
              snap_hs   = cl_hash_size_o;
              dly_t     = (ctl_delay >= 0) ? int'(ctl_delay) : $urandom_range(0, 2);
              dly       = 0;
              chk("blk_expected", 512'(exp_blk.size() != 0), 512'(1));
              if (exp_blk.size() != 0) begin
                e = exp_blk.pop_front();
                chk("blk_data", cl_block_o, e.data);
                chk("blk_size", 512'(cl_block_size_o), 512'(e.size));
                chk("blk_hash_size", 512'(cl_hash_size_o), 512'(e.hs));
              end
              chk("ready_low_on_trg", 512'(s_ready_o), 512'(0));
            end else begin
              chk("hold_blk_data", cl_block_o, snap_blk);
              chk("hold_blk_size", 512'(cl_block_size_o), 512'(snap_size));
            end
            if (dly >= dly_t) begin
              cl_state_i = BUSY;
              busy_left  = $urandom_range(2, 4);
              trig_seen  = 0;
            end else begin
              dly++;
            end
          end else if (trig_seen) begin
            chk("trg_held", 512'(cl_trg_o), 512'(1));
            trig_seen = 0;
          end
        end
        BUSY: begin
          chk("trg_drop", 512'(cl_trg_o), 512'(0));
          chk("ready_low_busy", 512'(s_ready_o), 512'(0));
          chk("busy_blk_stable", cl_block_o, snap_blk);
          chk("busy_size_stable", 512'({snap_hs, cl_block_size_o}), 512'({cl_hash_size_o, snap_size}));
          busy_left--;
          if (busy_left == 0) begin
            if (snap_size < 7'd64) begin
              for (int k = 0; k < 16; k++) h[k*32 +: 32] = $urandom;
              cl_hash_i = h;
              exp_hash.push_back(h);
              rel_t = $urandom_range(0, 2);
              dly   = 0;
              cl_state_i = DONE;
            end else begin
              cl_state_i = READY;
            end
          end
        end
        DONE: begin
          if (cl_trg_o) begin
            if (dly >= rel_t) begin
              cl_state_i = CLEAR;
              dly = 0;
            end else begin
              dly++;
            end
          end
        end
        default: cl_state_i = CLEAR;
      endcase
    end
  end

  // Digest consumer: compares each presented digest and enforces hold behaviour.
  initial begin : consumer
    bit           holding;
    int unsigned  hold_cnt, target;
    logic [511:0] snap, e;
    holding = 0; hold_cnt = 0; target = 0; snap = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        m_hash_ready_i = 1'b0;
        holding = 0;
        continue;
      end
      if (m_hash_ready_i) begin
        m_hash_ready_i = 1'b0;
        holding = 0;
        digests_seen++;
        chk("valid_drop", 512'(m_hash_valid_o), 512'(0));
        continue;
      end
      if (m_hash_valid_o) begin
        if (!holding) begin
          holding  = 1;
          hold_cnt = 0;
          snap     = m_hash_o;
          target   = hold_mode ? 10 : $urandom_range(0, 3);
          chk("digest_expected", 512'(exp_hash.size() != 0), 512'(1));
          if (exp_hash.size() != 0) begin
            e = exp_hash.pop_front();
            chk("digest", m_hash_o, e);
          end
        end else begin
          chk("digest_stable", m_hash_o, snap);
        end
        chk("ready_low_out", 512'(s_ready_o), 512'(0));
        if (hold_cnt >= target) m_hash_ready_i = 1'b1;
        else hold_cnt++;
      end else if (holding) begin
        chk("valid_held", 512'(m_hash_valid_o), 512'(1));
        holding = 0;
      end
    end
  end

  task automatic check_reset_outputs();
    chk("rst_s_ready", 512'(s_ready_o), 512'(0));
    chk("rst_trg", 512'(cl_trg_o), 512'(0));
    chk("rst_block", cl_block_o, '0);
    chk("rst_block_size", 512'(cl_block_size_o), 512'(0));
    chk("rst_hash_size", 512'(cl_hash_size_o), 512'(0));
    chk("rst_hash_valid", 512'(m_hash_valid_o), 512'(0));
    chk("rst_hash", m_hash_o, '0);
  endtask

  // Offer one byte until accepted; entered and left at #1 after a rising edge.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic hs, output bit ok);
    logic r;
    ok = 0;
    s_valid_i = 1'b1; s_data_i = d; s_last_i = last; hash_size_i = hs;
    for (int t = 0; t < 4000; t++) begin
      @(negedge clk); r = s_ready_o;
      @(posedge clk); #1;
      if (r) begin ok = 1; break; end
    end
    s_valid_i = 1'b0; s_last_i = 1'b0;
    if (!ok) chk("byte_accept_timeout", 512'(0), 512'(1));
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    exp_blk.delete();
    exp_hash.delete();
    s_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 512'(s_ready_o), 512'(1));
    @(posedge clk); #1;
  endtask

  // Send a message; reference blocks are derived from the byte list by 64-byte slicing.
  task automatic send_msg(input int len, input logic hs, input bit incr, input int rst_after);
    logic [7:0] msg[$];
    blk_t       b;
    int         sz;
    bit         ok;
    for (int i = 0; i < len; i++) msg.push_back(incr ? 8'(i + 1) : 8'($urandom));
    if (rst_after < 0) begin
      for (int k = 0; (k * 64 < len) || (k * 64 == len); k++) begin
        sz = (len - k * 64 > 64) ? 64 : len - k * 64;
        b.data = '0;
        for (int j = 0; j < sz; j++) b.data[j*8 +: 8] = msg[k*64 + j];
        b.size = 7'(sz);
        b.hs   = hs;
        exp_blk.push_back(b);
      end
      msgs_sent++;
    end
    for (int i = 0; i < len; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      send_byte(msg[i], logic'(i == len - 1), (i == 0) ? hs : 1'($urandom), ok);
      if (!ok) return;
      if (i == rst_after - 1) begin
        reset_mid();
        return;
      end
      if ((i == len - 1) || ((i % 64) == 63)) chk("ready_drop_after_close", 512'(s_ready_o), 512'(0));
    end
  endtask

  task automatic wait_done();
    for (int t = 0; t < 20000; t++) begin
      if ((digests_seen == msgs_sent) && (exp_blk.size() == 0)) break;
      @(posedge clk); #1;
    end
    chk("digest_count", 512'(digests_seen), 512'(msgs_sent));
    chk("blocks_left", 512'(exp_blk.size()), 512'(0));
  endtask

  initial begin : stim
    rst_n = 1'b0;
    s_valid_i = 1'b0; s_data_i = '0; s_last_i = 1'b0; hash_size_i = 1'b0;
    cl_state_i = CLEAR; cl_hash_i = '0; m_hash_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs();
    rst_n = 1'b1;
    #1;
    chk("ready_after_release", 512'(s_ready_o), 512'(1));
    @(posedge clk); #1;

    send_msg(3, 1'b0, 1'b1, -1);      // 01 02 03 -> one 3-byte block
    wait_done();
    send_msg(64, 1'b1, 1'b0, -1);     // full block then empty block
    wait_done();
    send_msg(130, 1'b0, 1'b0, -1);    // 64, 64, 2
    wait_done();
    hold_mode = 1'b1;
    send_msg(5, 1'b1, 1'b0, -1);      // digest held for 10 cycles
    wait_done();
    hold_mode = 1'b0;
    ctl_delay = 3;
    send_msg(70, 1'b0, 1'b0, -1);     // BUSY delayed by 3 cycles after trigger
    wait_done();
    ctl_delay = -1;
    send_msg(128, 1'b1, 1'b0, -1);
    for (int m = 0; m < 12; m++) send_msg($urandom_range(1, 200), 1'($urandom), 1'b0, -1);
    wait_done();
    send_msg(40, 1'b1, 1'b0, 20);     // reset after 20 bytes
    send_msg(1, 1'b0, 1'b0, -1);
    wait_done();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
